life_gen_ctrl: RTL and testbench
================================

Name: life_gen_ctrl

Overview:
- Generation controller for the life pipeline; decides once per frame whether that frame loads a seed, evolves one generation, or holds the board.
- Replaces the free-running speed counter in the tick stage.
- Drives the pipeline's update qualifier and the seed generator's write enable.
- Takes pulse requests from the UI debouncers: play/pause, single step, seed load.

Parameters:
- COUNTER_THRES, 60, accumulator threshold that triggers one generation.
- GEN_WIDTH, 16, width of the generation counter.

Ports:
- clk_in  in  1  system (pixel) clock
- rst_in  in  1  reset; one clock, reset is synchronous and active-low
- hcount_in  in  HCOUNT_WIDTH  current pixel x
- vcount_in  in  VCOUNT_WIDTH  current pixel y
- speed_in  in  LOG_MAX_SPEED  accumulator increment per frame while running
- play_in  in  1  one-cycle pulse; toggles run/pause
- step_in  in  1  one-cycle pulse; requests one generation while paused
- load_in  in  1  one-cycle pulse; requests a seed load
- seed_idx_in  in  LOG_NUM_SEED  pattern to load, sampled with load_in
- update_out  out  1  frame qualifier: evolve board this frame
- seed_en_out  out  1  frame qualifier: overwrite board from seed_gen this frame
- seed_idx_out  out  LOG_NUM_SEED  latched pattern index for seed_gen
- running_out  out  1  controller is in RUN
- gen_count_out  out  GEN_WIDTH  generations since last load

Behaviour:
- frame_tick = (hcount_in == BOARD_SIZE && vcount_in == BOARD_SIZE). It falls after the board scan and before the next one, so all frame qualifiers change only on the cycle after frame_tick and hold for one full frame.
- Request latching:
  - Pulses set sticky pending flags (play_pend, step_pend, load_pend).
  - seed_idx_in is captured into seed_idx_pend on load_in; a later load_in overwrites it.
  - A pulse coincident with frame_tick is acted on at that tick.
  - A flag clears on the tick that consumes it.
- States: PAUSE, RUN, LOAD, STEP. Reset enters PAUSE.
- At each frame_tick, pending requests are evaluated in priority order load > play > step:
  - PAUSE:
    - load_pend -> LOAD;
    - else play_pend -> RUN;
    - else step_pend -> STEP;
    - else stay.
  - RUN:
    - load_pend -> LOAD;
    - else play_pend -> PAUSE, and acc is kept;
    - else accumulate: if acc >= COUNTER_THRES then update frame and acc <= 0, else acc <= acc + speed_in.
  - LOAD:
    - Lasts exactly one frame; at the next tick go to PAUSE.
    - Pending play/step requests stay latched and are evaluated from PAUSE at the following tick.
  - STEP: lasts exactly one frame, then PAUSE.
  - step_pend arriving while in RUN is discarded at that tick.
- Outputs, all registered and updated on the cycle after frame_tick:
  - seed_en_out = 1 iff the frame is LOAD; seed_idx_out <= seed_idx_pend on entering LOAD.
  - update_out = 1 iff the frame is STEP or a RUN evolve frame; never together with seed_en_out.
  - gen_count_out: cleared on entering LOAD; +1 on each update frame; wraps modulo 2^GEN_WIDTH.
  - acc: 8 bits, cleared on LOAD; speed_in zero-extended. speed_in = 0 while running gives no updates.
- Reset (rst_in == 0, any cycle, including mid-frame):
  - state PAUSE; all pending flags, acc and gen_count cleared;
  - update_out, seed_en_out, running_out and seed_idx_out are 0 on the cycle after reset is sampled;
  - a half-issued qualifier frame is abandoned.

Decomposition:
- In common.svh, next to existing constants: typedef enum ctrl_state_t {PAUSE, RUN, LOAD, STEP} and localparam COUNTER_THRES.
- One sub-module, gen_rate_acc: owns acc, takes clear/step-enable/speed, returns evolve_now. Isolates the arithmetic from the FSM.

Test Plan:
- Release reset, no pulses, 3 frames -> running_out=0, update_out=0, seed_en_out=0, gen_count_out=0 throughout.
- load_in with seed_idx_in=2 mid-frame -> on the cycle after the next frame_tick: seed_en_out=1 and seed_idx_out=2 for exactly one frame; then PAUSE with gen_count_out=0.
- play_in, speed_in=20 -> running_out=1; acc goes 0, 20, 40, 60, so update_out is high on the 4th RUN frame; repeats every 4 frames; gen_count_out increments once per update frame.
- Paused, step_in twice in the same frame -> exactly one STEP frame with update_out=1; gen_count_out +1.
- load_in and play_in pulsed on the same cycle as frame_tick while RUN -> LOAD frame first, then PAUSE, then RUN at the following tick.
- rst_in=0 for one cycle during a RUN update frame -> update_out=0 and running_out=0 the next cycle; gen_count_out=0; no update_out until a new play_in.

Source files
------------

// File: rtl/life_gen_ctrl_pkg.sv
// Shared constants and state encoding for the life generation controller.
package life_gen_ctrl_pkg;
  localparam int HCOUNT_WIDTH  = 11;
  localparam int VCOUNT_WIDTH  = 10;
  localparam int BOARD_SIZE    = 64;
  localparam int LOG_MAX_SPEED = 6;
  localparam int LOG_NUM_SEED  = 2;
  localparam int ACC_WIDTH     = 8;
  localparam int COUNTER_THRES = 60;

  typedef enum logic [1:0] {PAUSE, RUN, LOAD, STEP} ctrl_state_t;
endpackage

// File: rtl/life_gen_ctrl_if.sv
// Raster position, UI request pulses and frame qualifiers of the generation controller.
interface life_gen_ctrl_if import life_gen_ctrl_pkg::*; #(
  parameter int GEN_WIDTH = 16
) ();
  logic [HCOUNT_WIDTH-1:0]  hcount_in;
  logic [VCOUNT_WIDTH-1:0]  vcount_in;
  logic [LOG_MAX_SPEED-1:0] speed_in;
  logic                     play_in;
  logic                     step_in;
  logic                     load_in;
  logic [LOG_NUM_SEED-1:0]  seed_idx_in;
  logic                     update_out;
  logic                     seed_en_out;
  logic [LOG_NUM_SEED-1:0]  seed_idx_out;
  logic                     running_out;
  logic [GEN_WIDTH-1:0]     gen_count_out;

  modport master (
    output hcount_in, vcount_in, speed_in, play_in, step_in, load_in, seed_idx_in,
    input  update_out, seed_en_out, seed_idx_out, running_out, gen_count_out
  );
  modport slave (
    input  hcount_in, vcount_in, speed_in, play_in, step_in, load_in, seed_idx_in,
    output update_out, seed_en_out, seed_idx_out, running_out, gen_count_out
  );
endinterface

// File: rtl/life_gen_ctrl_acc.sv
// Speed accumulator: adds speed once per running frame, fires evolve_now when the threshold is reached.
module gen_rate_acc #(
  parameter int ACC_WIDTH   = 8,
  parameter int SPEED_WIDTH = 6,
  parameter int THRES       = 60
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clear_in,
  input  logic                   step_en_in,
  input  logic [SPEED_WIDTH-1:0] speed_in,
  output logic                   evolve_now
);
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  // Threshold is tested on the value held before this frame's add.
  assign evolve_now = step_en_in && (acc_q >= ACC_WIDTH'(THRES));

  always_comb begin
    acc_d = acc_q;
    if (clear_in)        acc_d = '0;
    else if (evolve_now) acc_d = '0;
    else if (step_en_in) acc_d = acc_q + ACC_WIDTH'(speed_in);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) acc_q <= '0;
    else         acc_q <= acc_d;
  end
endmodule

// File: rtl/life_gen_ctrl.sv
// Per-frame generation controller: chooses LOAD / evolve / hold at each frame tick.
module life_gen_ctrl import life_gen_ctrl_pkg::*; #(
  parameter int COUNTER_THRES = life_gen_ctrl_pkg::COUNTER_THRES,
  parameter int GEN_WIDTH     = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  life_gen_ctrl_if.slave   bus
);
  ctrl_state_t             state_q, state_d;
  logic                    play_pend_q, play_pend_d;
  logic                    step_pend_q, step_pend_d;
  logic                    load_pend_q, load_pend_d;
  logic [LOG_NUM_SEED-1:0] seed_idx_pend_q, seed_idx_pend_d;
  logic [LOG_NUM_SEED-1:0] seed_idx_q, seed_idx_d;
  logic                    update_q, update_d;
  logic                    seed_en_q, seed_en_d;
  logic [GEN_WIDTH-1:0]    gen_q, gen_d;

  logic                    frame_tick;
  logic                    play_eff, step_eff, load_eff;
  logic [LOG_NUM_SEED-1:0] seed_idx_eff;
  logic                    acc_clear, acc_step, evolve_now;

  // Tick sits just past the board scan, so qualifiers never change mid-board.
  assign frame_tick = (bus.hcount_in == HCOUNT_WIDTH'(BOARD_SIZE)) &&
                      (bus.vcount_in == VCOUNT_WIDTH'(BOARD_SIZE));

  // A pulse on the tick cycle is folded in so it is acted on immediately.
  assign play_eff     = play_pend_q | bus.play_in;
  assign step_eff     = step_pend_q | bus.step_in;
  assign load_eff     = load_pend_q | bus.load_in;
  assign seed_idx_eff = bus.load_in ? bus.seed_idx_in : seed_idx_pend_q;
  assign acc_step     = frame_tick && (state_q == RUN) && !load_eff && !play_eff;

  gen_rate_acc #(
    .ACC_WIDTH   (ACC_WIDTH),
    .SPEED_WIDTH (LOG_MAX_SPEED),
    .THRES       (COUNTER_THRES)
  ) u_acc (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear_in   (acc_clear),
    .step_en_in (acc_step),
    .speed_in   (bus.speed_in),
    .evolve_now (evolve_now)
  );

  always_comb begin
    state_d         = state_q;
    play_pend_d     = play_eff;
    step_pend_d     = step_eff;
    load_pend_d     = load_eff;
    seed_idx_pend_d = seed_idx_eff;
    seed_idx_d      = seed_idx_q;
    update_d        = update_q;
    seed_en_d       = seed_en_q;
    gen_d           = gen_q;
    acc_clear       = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        PAUSE: begin
          if (load_eff)      begin state_d = LOAD;  load_pend_d = 1'b0; end
          else if (play_eff) begin state_d = RUN;   play_pend_d = 1'b0; end
          else if (step_eff) begin state_d = STEP;  step_pend_d = 1'b0; end
        end
        RUN: begin
          step_pend_d = 1'b0;
          if (load_eff)      begin state_d = LOAD;  load_pend_d = 1'b0; end
          else if (play_eff) begin state_d = PAUSE; play_pend_d = 1'b0; end
        end
        default: state_d = PAUSE;
      endcase
      seed_en_d = (state_d == LOAD);
      update_d  = (state_d == STEP) || evolve_now;
      if (state_d == LOAD) begin
        acc_clear  = 1'b1;
        gen_d      = '0;
        seed_idx_d = seed_idx_eff;
      end else if (update_d) begin
        gen_d = gen_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q         <= PAUSE;
      play_pend_q     <= 1'b0;
      step_pend_q     <= 1'b0;
      load_pend_q     <= 1'b0;
      seed_idx_pend_q <= '0;
      seed_idx_q      <= '0;
      update_q        <= 1'b0;
      seed_en_q       <= 1'b0;
      gen_q           <= '0;
    end else begin
      state_q         <= state_d;
      play_pend_q     <= play_pend_d;
      step_pend_q     <= step_pend_d;
      load_pend_q     <= load_pend_d;
      seed_idx_pend_q <= seed_idx_pend_d;
      seed_idx_q      <= seed_idx_d;
      update_q        <= update_d;
      seed_en_q       <= seed_en_d;
      gen_q           <= gen_d;
    end
  end

  assign bus.update_out    = update_q;
  assign bus.seed_en_out   = seed_en_q;
  assign bus.seed_idx_out  = seed_idx_q;
  assign bus.running_out   = (state_q == RUN);
  assign bus.gen_count_out = gen_q;
endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl using short synthetic frames (tick + a few idle cycles).
module tb_life_gen_ctrl;
  import life_gen_ctrl_pkg::*;

  localparam int FRAME_IDLE = 6;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  life_gen_ctrl_if #(.GEN_WIDTH(16)) bus ();

  life_gen_ctrl #(.COUNTER_THRES(60), .GEN_WIDTH(16)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic tk, input logic pl, input logic st, input logic ld,
                     input logic [1:0] idx);
    @(negedge clk);
    bus.hcount_in   = tk ? HCOUNT_WIDTH'(BOARD_SIZE) : HCOUNT_WIDTH'(3);
    bus.vcount_in   = tk ? VCOUNT_WIDTH'(BOARD_SIZE) : VCOUNT_WIDTH'(3);
    bus.play_in     = pl;
    bus.step_in     = st;
    bus.load_in     = ld;
    bus.seed_idx_in = idx;
  endtask

  task automatic frame(input logic pl, input logic ld, input logic [1:0] idx);
    cyc(1'b1, pl, 1'b0, ld, idx);
    repeat (FRAME_IDLE) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic pulse(input logic pl, input logic st, input logic ld, input logic [1:0] idx);
    cyc(1'b0, pl, st, ld, idx);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.hcount_in = '0; bus.vcount_in = '0; bus.speed_in = '0;
    bus.play_in = 1'b0; bus.step_in = 1'b0; bus.load_in = 1'b0; bus.seed_idx_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_running", 32'(bus.running_out), 0);
    chk("rst_update",  32'(bus.update_out), 0);
    chk("rst_seed_en", 32'(bus.seed_en_out), 0);
    chk("rst_seed_idx", 32'(bus.seed_idx_out), 0);
    chk("rst_gen",     32'(bus.gen_count_out), 0);

    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 1'b0, 2'd0);
      chk("idle_flags", 32'({bus.running_out, bus.update_out, bus.seed_en_out}), 0);
      chk("idle_gen", 32'(bus.gen_count_out), 0);
    end

    // seed load requested mid-frame
    pulse(1'b0, 1'b0, 1'b1, 2'd2);
    chk("load_wait", 32'(bus.seed_en_out), 0);
    frame(1'b0, 1'b0, 2'd0);
    chk("load_seed_en", 32'(bus.seed_en_out), 1);
    chk("load_seed_idx", 32'(bus.seed_idx_out), 2);
    chk("load_update", 32'(bus.update_out), 0);
    frame(1'b0, 1'b0, 2'd0);
    chk("after_load_seed_en", 32'(bus.seed_en_out), 0);
    chk("after_load_running", 32'(bus.running_out), 0);
    chk("after_load_gen", 32'(bus.gen_count_out), 0);
    chk("after_load_idx", 32'(bus.seed_idx_out), 2);

    // run at speed 20: acc seen at RUN ticks is 0,20,40,60 -> evolve every 4th tick
    bus.speed_in = 6'd20;
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    frame(1'b0, 1'b0, 2'd0);
    chk("run_enter", 32'(bus.running_out), 1);
    chk("run_enter_upd", 32'(bus.update_out), 0);
    for (int i = 1; i <= 8; i++) begin
      frame(1'b0, 1'b0, 2'd0);
      chk("run_update", 32'(bus.update_out), (i % 4 == 0) ? 1 : 0);
      chk("run_gen", 32'(bus.gen_count_out), 32'(i / 4));
      chk("run_seed_en", 32'(bus.seed_en_out), 0);
    end

    // reset in the middle of an update frame
    chk("pre_rst_update", 32'(bus.update_out), 1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("mid_rst_flags", 32'({bus.running_out, bus.update_out, bus.seed_en_out}), 0);
    chk("mid_rst_gen", 32'(bus.gen_count_out), 0);
    chk("mid_rst_idx", 32'(bus.seed_idx_out), 0);
    for (int i = 0; i < 2; i++) begin
      frame(1'b0, 1'b0, 2'd0);
      chk("post_rst_flags", 32'({bus.running_out, bus.update_out}), 0);
    end

    // load + play on the tick while running: LOAD, then PAUSE, then RUN
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    frame(1'b0, 1'b0, 2'd0);
    chk("rerun", 32'(bus.running_out), 1);
    frame(1'b1, 1'b1, 2'd1);
    chk("coinc_seed_en", 32'(bus.seed_en_out), 1);
    chk("coinc_idx", 32'(bus.seed_idx_out), 1);
    chk("coinc_running", 32'(bus.running_out), 0);
    frame(1'b0, 1'b0, 2'd0);
    chk("coinc_pause", 32'({bus.running_out, bus.seed_en_out}), 0);
    frame(1'b0, 1'b0, 2'd0);
    chk("coinc_run", 32'(bus.running_out), 1);

    // speed 0 never evolves; a step while running is dropped
    bus.speed_in = 6'd0;
    for (int i = 0; i < 5; i++) begin
      frame(1'b0, 1'b0, 2'd0);
      chk("speed0_update", 32'(bus.update_out), 0);
    end
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    frame(1'b0, 1'b0, 2'd0);
    chk("run_step_drop", 32'({bus.running_out, bus.update_out}), 32'b10);
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    frame(1'b0, 1'b0, 2'd0);
    chk("pause_again", 32'(bus.running_out), 0);
    frame(1'b0, 1'b0, 2'd0);
    chk("no_stale_step", 32'(bus.update_out), 0);

    // two step pulses in one paused frame give a single STEP frame
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    frame(1'b0, 1'b0, 2'd0);
    chk("step_update", 32'(bus.update_out), 1);
    chk("step_running", 32'(bus.running_out), 0);
    chk("step_gen", 32'(bus.gen_count_out), 1);
    frame(1'b0, 1'b0, 2'd0);
    chk("step_once", 32'(bus.update_out), 0);
    chk("step_gen_hold", 32'(bus.gen_count_out), 1);
    frame(1'b0, 1'b0, 2'd0);
    chk("step_idle", 32'(bus.update_out), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
